// File: rtl/cim_pkg.sv
// Shared definitions for the pool -> fc flatten adapter.
//   flat_state_e : flatten FSM states (IDLE, SERIAL, WAIT_FC, START)
//   flat_addr_w  : address width for a channels x width x width buffer
//   flat_addr    : channel-major flattened address ch*width^2 + pix
//   FLAT_ADDR_W_DEFAULT : address width for the default 5 x 12 x 12 geometry
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERIAL,
    WAIT_FC,
    START
  } flat_state_e;

  function automatic int unsigned flat_addr_w(input int unsigned channels,
                                              input int unsigned width);
    int unsigned n;
    n = channels * width * width;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned FLAT_ADDR_W_DEFAULT = flat_addr_w(5, 12);

  function automatic int unsigned flat_addr(input int unsigned ch,
                                            input int unsigned pix,
                                            input int unsigned width);
    return ch * width * width + pix;
  endfunction

endpackage

// File: rtl/pool_fc_flatten.sv
// pool_fc_flatten: adapter between a pool_layer and the following fc_layer.
// Takes one pixel vector (all channels in parallel) per handshake, writes its
// elements one per cycle into the fc input buffer in channel-major order, and
// after a full frame issues a one-cycle start to the fc_layer once it is idle.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   i_valid, i_data pooled pixel vector from the pool stage
//   o_busy          cannot accept i_valid this cycle (combinational)
//   i_fc_busy       fc_layer busy flag
//   o_ibuf_we/_wr_data/_addr  registered fc input-buffer write port
//   o_start         registered one-cycle start pulse to fc_layer
//
// Optional build macro FLATTEN_RELU_EN: clamps negative (signed) elements to
// zero on the write path; undefined, data passes through bit-exact.
module pool_fc_flatten
  import cim_pkg::*;
#(
  parameter int unsigned input_channels = 5,
  parameter int unsigned img_width      = 12,
  parameter int unsigned datatype_size  = 8,
  parameter int unsigned input_size     = input_channels * img_width * img_width
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         i_valid,
  input  logic [input_channels-1:0][datatype_size-1:0] i_data,
  output logic                                         o_busy,
  input  logic                                         i_fc_busy,
  output logic                                         o_ibuf_we,
  output logic [datatype_size-1:0]                     o_ibuf_wr_data,
  output logic [$clog2(input_size)-1:0]                o_ibuf_addr,
  output logic                                         o_start
);

  localparam int unsigned AW  = $clog2(input_size);
  localparam int unsigned PIX = img_width * img_width;
  localparam int unsigned CW  = (input_channels > 1) ? $clog2(input_channels) : 1;
  localparam int unsigned PW  = (PIX > 1) ? $clog2(PIX) : 1;

  typedef logic [input_channels-1:0][datatype_size-1:0] vec_t;

  flat_state_e              state_q;
  logic [CW-1:0]            ch_q;
  logic [CW-1:0]            ch_d;
  logic [PW-1:0]            pix_q;
  logic [PW-1:0]            pix_d;
  vec_t                     vec_q;
  logic                     we_q;
  logic [datatype_size-1:0] data_q;
  logic [AW-1:0]            addr_q;
  logic                     start_q;
  logic                     busy;
  logic                     last_ch;
  logic                     frame_end;

  function automatic logic [datatype_size-1:0] clamp(input logic [datatype_size-1:0] v);
`ifdef FLATTEN_RELU_EN
    return v[datatype_size-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    ch_d      = ch_q + 1'b1;
    last_ch   = (ch_q == CW'(input_channels - 1));
    frame_end = (pix_q == PW'(PIX - 1));
    pix_d     = frame_end ? '0 : pix_q + 1'b1;
    busy      = (state_q != IDLE) || ((pix_q == '0) && i_fc_busy);
  end

  // ch_q names the element currently presented on the write port. Element 0
  // is registered straight from i_data on acceptance and element k+1 while
  // element k is shown, so writes land on the cycles right after acceptance
  // and the FSM returns to IDLE the cycle after the last write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pix_q   <= '0;
      vec_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && !busy) begin
            vec_q   <= i_data;
            ch_q    <= '0;
            we_q    <= 1'b1;
            data_q  <= clamp(i_data[0]);
            addr_q  <= AW'(flat_addr(32'd0, 32'(pix_q), img_width));
            state_q <= SERIAL;
          end
        end
        SERIAL: begin
          if (last_ch) begin
            we_q    <= 1'b0;
            pix_q   <= pix_d;
            state_q <= frame_end ? WAIT_FC : IDLE;
          end else begin
            ch_q   <= ch_d;
            data_q <= clamp(vec_q[ch_d]);
            addr_q <= AW'(flat_addr(32'(ch_d), 32'(pix_q), img_width));
          end
        end
        WAIT_FC: begin
          if (!i_fc_busy) begin
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy         = busy;
  assign o_ibuf_we      = we_q;
  assign o_ibuf_wr_data = data_q;
  assign o_ibuf_addr    = addr_q;
  assign o_start        = start_q;

endmodule

// File: tb/tb_pool_fc_flatten.sv
// Self-checking bench for pool_fc_flatten: table-driven vectors, hand-written
// reset / fc-busy sequences and randomized full frames checked against a
// transaction-level reference model (expected write list with due cycles).
`timescale 1ns/1ps
module tb_pool_fc_flatten;
  import cim_pkg::*;

  localparam int C  = 5;
  localparam int W  = 12;
  localparam int D  = 8;
  localparam int P  = W * W;
  localparam int N  = C * P;
  localparam int AW = FLAT_ADDR_W_DEFAULT;

  typedef logic [C-1:0][D-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_fc_busy = 1'b0;
  vec_t          i_data = '0;
  logic          o_busy;
  logic          o_ibuf_we;
  logic [D-1:0]  o_ibuf_wr_data;
  logic [AW-1:0] o_ibuf_addr;
  logic          o_start;

  always #5 clk = ~clk;

  pool_fc_flatten #(
    .input_channels(C),
    .img_width     (W),
    .datatype_size (D),
    .input_size    (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .i_data        (i_data),
    .o_busy        (o_busy),
    .i_fc_busy     (i_fc_busy),
    .o_ibuf_we     (o_ibuf_we),
    .o_ibuf_wr_data(o_ibuf_wr_data),
    .o_ibuf_addr   (o_ibuf_addr),
    .o_start       (o_start)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int           cyc;
    int           addr;
    logic [D-1:0] data;
  } wr_t;

  typedef struct {
    vec_t in;
    vec_t exp;
  } tv_t;

  // reference model state
  wr_t wq[$];
  int  cyc = 0;
  int  pix_m = 0;
  int  busy_until = -1;
  int  wait_from = 0;
  int  start_cyc = -1;
  int  starts = 0;
  bit  frame_pend = 1'b0;

  // observations of the DUT write port
  logic [D-1:0] wr_log [N];
  int  dut_we_cnt = 0;
  int  last_wr_cyc = -1;
  int  last_wr_addr = -1;
  int  start_seen = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [D-1:0] relu(input logic [D-1:0] v);
`ifdef FLATTEN_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int c = 0; c < C; c++) v[c] = D'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic model_reset();
    wq.delete();
    pix_m      = 0;
    busy_until = -1;
    start_cyc  = -1;
    frame_pend = 1'b0;
  endtask

  // Called #1 after inputs are applied for the current cycle: checks every
  // output against the model, then lets the model react to this cycle.
  task automatic sample();
    bit exp_we;
    bit exp_busy;
    bit exp_start;
    wr_t w;
    cyc++;
    while (wq.size() > 0 && wq[0].cyc < cyc) void'(wq.pop_front());
    exp_we = (wq.size() > 0) && (wq[0].cyc == cyc);
    chk("ibuf_we", 32'(o_ibuf_we), 32'(exp_we));
    if (o_ibuf_we === 1'b1) begin
      dut_we_cnt++;
      last_wr_cyc  = cyc;
      last_wr_addr = int'(o_ibuf_addr);
      wr_log[int'(o_ibuf_addr)] = o_ibuf_wr_data;
    end
    if (exp_we) begin
      chk("ibuf_addr", 32'(o_ibuf_addr), 32'(wq[0].addr));
      chk("ibuf_data", 32'(o_ibuf_wr_data), 32'(wq[0].data));
      void'(wq.pop_front());
    end
    exp_start = (start_cyc == cyc);
    exp_busy  = (cyc <= busy_until) || (frame_pend && cyc >= wait_from) ||
                exp_start || (pix_m == 0 && i_fc_busy);
    chk("busy", 32'(o_busy), 32'(exp_busy));
    chk("start", 32'(o_start), 32'(exp_start));
    if (o_start === 1'b1) start_seen = cyc;
    if (exp_start) begin
      starts++;
      start_cyc = -1;
    end
    if (i_valid && !exp_busy) begin
      for (int c = 0; c < C; c++) begin
        w.cyc  = cyc + 1 + c;
        w.addr = c * P + pix_m;
        w.data = relu(i_data[c]);
        wq.push_back(w);
      end
      busy_until = cyc + C;
      if (pix_m == P - 1) begin
        pix_m      = 0;
        frame_pend = 1'b1;
        wait_from  = cyc + C + 1;
      end else begin
        pix_m++;
      end
    end
    if (frame_pend && cyc >= wait_from && !i_fc_busy) begin
      start_cyc  = cyc + 1;
      frame_pend = 1'b0;
    end
  endtask

  // Entered and left at a falling edge.
  task automatic tick(input logic v, input vec_t d, input logic fb);
    i_valid   = v;
    i_data    = d;
    i_fc_busy = fb;
    #1;
    sample();
    @(negedge clk);
  endtask

  // Streams random vectors until the frame's start pulse. fc_busy is held
  // during the frame (except at pixel 0) when fb_mid, and for `hold` cycles
  // after the frame's last write.
  task automatic run_frame(input bit fb_mid, input int hold);
    int  s0;
    int  held;
    int  budget;
    bit  fb;
    s0 = starts;
    held = 0;
    budget = 4000;
    while (starts == s0 && budget > 0) begin
      if (frame_pend && cyc + 1 >= wait_from) begin
        fb = (held < hold);
        held++;
      end else begin
        fb = fb_mid && (pix_m != 0);
      end
      tick($urandom_range(0, 3) != 0, rand_vec(), fb);
      budget--;
    end
    chk("frame_timeout", 32'(starts - s0), 32'd1);
  endtask

  tv_t tv[3];

  initial begin
    int w0;
    int p;
    vec_t dv;

    tv[0].in  = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    tv[0].exp = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    tv[1].in  = {8'h80, 8'hFF, 8'h00, 8'h7F, 8'h85};
    tv[2].in  = {8'h40, 8'h81, 8'h7F, 8'h80, 8'h01};
`ifdef FLATTEN_RELU_EN
    tv[1].exp = {8'h00, 8'h00, 8'h00, 8'h7F, 8'h00};
    tv[2].exp = {8'h40, 8'h00, 8'h7F, 8'h00, 8'h01};
`else
    tv[1].exp = tv[1].in;
    tv[2].exp = tv[2].in;
`endif

    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", 32'(o_ibuf_we), 32'd0);
    chk("rst_data", 32'(o_ibuf_wr_data), 32'd0);
    chk("rst_addr", 32'(o_ibuf_addr), 32'd0);
    chk("rst_start", 32'(o_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(1'b0, '0, 1'b0);

    // table vectors at pixels 0,1,2
    for (int i = 0; i < 3; i++) begin
      p = pix_m;
      tick(1'b1, tv[i].in, 1'b0);
      repeat (C + 1) tick(1'b0, '0, 1'b0);
      for (int c = 0; c < C; c++)
        chk($sformatf("tv%0d_ch%0d", i, c), 32'(wr_log[c * P + p]), 32'(tv[i].exp[c]));
    end
    chk("tv_first_addr_ch4", 32'(last_wr_addr), 32'(4 * P + 2));

    // reset asserted mid-write drops the write port at once
    tick(1'b1, rand_vec(), 1'b0);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    chk("pre_rst_we", 32'(o_ibuf_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(o_ibuf_we), 32'd0);
    chk("mid_rst_addr", 32'(o_ibuf_addr), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(1'b0, '0, 1'b0);

    // full frame from address 0, fc idle
    dut_we_cnt = 0;
    run_frame(1'b0, 0);
    chk("frame_writes", 32'(dut_we_cnt), 32'(N));
    chk("frame_last_addr", 32'(last_wr_addr), 32'(N - 1));
    chk("frame_start_gap", 32'(start_seen - last_wr_cyc), 32'd2);

    // fc busy after start: vectors at pixel 0 are held off
    w0 = dut_we_cnt;
    repeat (4) tick(1'b1, rand_vec(), 1'b1);
    chk("held_off_writes", 32'(dut_we_cnt - w0), 32'd0);
    dv = rand_vec();
    tick(1'b1, dv, 1'b0);
    repeat (C + 1) tick(1'b0, '0, 1'b1);
    chk("accepted_writes", 32'(dut_we_cnt - w0), 32'(C));
    chk("accepted_ch0", 32'(wr_log[0]), 32'(relu(dv[0])));

    // frame end with fc busy for 10 more cycles
    run_frame(1'b1, 10);
    chk("busy_start_gap", 32'(start_seen - last_wr_cyc), 32'd12);
    repeat (3) tick(1'b1, rand_vec(), 1'b1);
    repeat (3) tick(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pool_fc_flatten.md
Name: pool_fc_flatten

Overview:
- Inter-layer adapter between a pool_layer and the following fc_layer.
- Accepts one per-channel pixel vector per handshake from the pool stage (all channels in parallel).
- Serialises the vector into the fc_layer input buffer in channel-major flattened order.
- After a full frame is written, issues a one-cycle start to the fc_layer, respecting its busy flag.

Parameters:
- input_channels, 5, channels per pooled pixel vector
- img_width, 12, pooled feature-map width (square map)
- datatype_size, 8, bits per element
- input_size, input_channels*img_width**2 (720), fc input vector length; must equal the fc_layer input_size

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- i_valid  in  1  pool output vector valid this cycle
- i_data  in  [datatype_size-1:0] x [input_channels-1:0]  pooled pixel, one element per channel
- o_busy  out  1  block cannot accept i_valid (drives pool i_next_busy)
- i_fc_busy  in  1  fc_layer o_busy
- o_ibuf_we  out  1  fc input-buffer write enable
- o_ibuf_wr_data  out  datatype_size  fc input-buffer write data
- o_ibuf_addr  out  $clog2(input_size)  fc input-buffer address
- o_start  out  1  one-cycle start pulse to fc_layer i_start

Behaviour:
- Reset (rst=0, async): state IDLE; pix_cnt=0, ch_cnt=0; vector register cleared. o_ibuf_we=0, o_ibuf_wr_data=0, o_ibuf_addr=0, o_start=0.
- States: IDLE, SERIAL, WAIT_FC, START.
- o_busy (combinational):
  - 1 in SERIAL, WAIT_FC and START.
  - 1 in IDLE when pix_cnt==0 and i_fc_busy==1 (no new frame while fc computes).
  - 0 otherwise.
- IDLE: i_valid && !o_busy captures i_data into the vector register, clears ch_cnt, and moves to SERIAL. i_valid while o_busy=1 is ignored; no capture, no error.
- SERIAL: one registered write per cycle.
  - o_ibuf_we=1, o_ibuf_wr_data=vec[ch_cnt], o_ibuf_addr=ch_cnt*img_width**2+pix_cnt.
  - Writes appear at T+1..T+input_channels for a vector accepted at cycle T.
  - After the ch_cnt==input_channels-1 write:
    - If pix_cnt<img_width**2-1: pix_cnt++, go to IDLE.
    - Else (frame end): pix_cnt wraps to 0, go to WAIT_FC.
- WAIT_FC: o_ibuf_we=0. Stay while i_fc_busy=1. On i_fc_busy=0, go to START.
- START: o_start=1 (registered) for exactly one cycle, then IDLE.
  - Contract: fc raises i_fc_busy no later than the cycle after o_start.
- Throughput: one vector per input_channels+1 cycles.
- Address arithmetic: unsigned, width $clog2(input_size); maximum address input_size-1, never exceeded.
- Reset mid-frame: the partial frame is discarded, writes stop immediately, and the next frame restarts at address 0. The fc buffer contents are left as-is.

Optional Feature:
- Macro FLATTEN_RELU_EN.
  - Defined: each element is treated as signed two's complement; a negative value (MSB=1) is written as 0, non-negative values pass unchanged. The clamp is applied on the write path with no added latency.
  - Undefined: data passes through bit-exact.

Decomposition:
- Shared package cim_pkg:
  - flatten state enum (IDLE/SERIAL/WAIT_FC/START)
  - a function returning the flattened address (channel, pixel, img_width)
  - a localparam helper for the address width
- No sub-module: the counters, FSM and write path form one flat module.

Test Plan:
1. Reset with i_fc_busy=0 -> all outputs 0, o_busy=0; asserting rst mid-SERIAL drops o_ibuf_we in the same cycle.
2. Single vector {10,20,30,40,50} at pix 0 -> writes addr 0,144,288,432,576 with data 10..50 on cycles T+1..T+5; o_busy high T+1..T+5, low at T+6.
3. Full frame of 144 vectors, i_fc_busy=0 -> 720 writes with last addr 719 (ch 4, pix 143); WAIT_FC one cycle; o_start pulses once, 2 cycles after the last write; pix_cnt returns to 0.
4. Frame end with i_fc_busy=1 held 10 cycles -> no o_start and o_busy=1 throughout; o_start pulses the cycle after the first sampled i_fc_busy=0.
5. IDLE at pix 0 with i_fc_busy=1 and i_valid=1 -> o_busy=1, no capture, no writes; after i_fc_busy falls, the vector is accepted.
6. Element 0x85 with FLATTEN_RELU_EN -> written 0x00; without the macro -> 0x85; 0x7F is written 0x7F in both builds.
